// File: rtl/tile_pkg.sv
// Shared definitions for the L1 tile memory: geometry constants, the beat
// record carried from the tile BRAM into the dot-product pipeline, and the
// read-sequencer state encoding.
package tile_pkg;

  localparam int MAN_WIDTH  = 256;
  localparam int EXP_WIDTH  = 8;
  localparam int BRAM_DEPTH = 512;
  localparam int ADDR_WIDTH = $clog2(BRAM_DEPTH);
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1;

  // One paired left/right beat; last marks the final beat of a burst.
  typedef struct packed {
    logic [MAN_WIDTH-1:0] man_left;
    logic [MAN_WIDTH-1:0] man_right;
    logic [EXP_WIDTH-1:0] exp_left;
    logic [EXP_WIDTH-1:0] exp_right;
    logic                 last;
  } tile_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/tile_rd_fifo.sv
// Small synchronous FIFO of tile beats. Absorbs the one-cycle BRAM read
// latency so the reader can keep streaming while the consumer stalls.
// Simultaneous push and pop are allowed, including when full.
module tile_rd_fifo
  import tile_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  tile_beat_t       i_push_data,
  input  logic             i_pop,
  output tile_beat_t       o_head,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  tile_beat_t       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             valid_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(FIFO_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign pop_ok_s  = i_pop & valid_r;
  assign push_ok_s = i_push & ((count_r != CNT_W'(FIFO_DEPTH)) | pop_ok_s);

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Beat storage; cleared on reset so stale lines can never resurface.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= i_push_data;
    end
  end

  // Pointers, count and the registered non-empty flag.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_next_s;
      valid_r <= (count_next_s != {CNT_W{1'b0}});
    end
  end

  assign o_head  = mem_r[rd_ptr_r];
  assign o_valid = valid_r;
  assign o_count = count_r;

endmodule

// File: rtl/tile_bram_reader.sv
// Read-side sequencer for the L1 tile memory. Accepts a burst command,
// drives the four tile BRAM read ports in lockstep, and streams paired
// left/right beats to the dot-product pipeline through a small FIFO.
// Issue is credit-limited so a stalled consumer never loses a line.
module tile_bram_reader
  import tile_pkg::*;
#(
  parameter int MAN_WIDTH  = tile_pkg::MAN_WIDTH,
  parameter int EXP_WIDTH  = tile_pkg::EXP_WIDTH,
  parameter int BRAM_DEPTH = tile_pkg::BRAM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(BRAM_DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] i_cmd_left_base,
  input  logic [ADDR_WIDTH-1:0] i_cmd_right_base,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  output logic [ADDR_WIDTH-1:0] o_man_left_rd_addr,
  output logic [ADDR_WIDTH-1:0] o_exp_left_rd_addr,
  output logic [ADDR_WIDTH-1:0] o_man_right_rd_addr,
  output logic [ADDR_WIDTH-1:0] o_exp_right_rd_addr,
  output logic                  o_man_left_rd_en,
  output logic                  o_man_right_rd_en,
  output logic                  o_exp_left_rd_en,
  output logic                  o_exp_right_rd_en,
  input  logic [MAN_WIDTH-1:0]  i_man_left_rd_data,
  input  logic [MAN_WIDTH-1:0]  i_man_right_rd_data,
  input  logic [EXP_WIDTH-1:0]  i_exp_left_rd_data,
  input  logic [EXP_WIDTH-1:0]  i_exp_right_rd_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [MAN_WIDTH-1:0]  o_man_left,
  output logic [MAN_WIDTH-1:0]  o_man_right,
  output logic [EXP_WIDTH-1:0]  o_exp_left,
  output logic [EXP_WIDTH-1:0]  o_exp_right,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(BRAM_DEPTH);

  rd_state_t             state_r;
  rd_state_t             state_next_s;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [LEN_WIDTH-1:0]  issue_cnt_r;
  logic [LEN_WIDTH-1:0]  len_sat_s;
  logic [ADDR_WIDTH-1:0] left_addr_r;
  logic [ADDR_WIDTH-1:0] right_addr_r;
  logic                  inflight_r;
  logic                  inflight_last_r;
  logic                  cmd_ready_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  accept_s;
  logic                  issue_s;
  logic                  last_issue_s;
  logic                  pop_s;
  logic                  credit_ok_s;
  logic                  drained_s;
  logic [CNT_W-1:0]      fifo_count_s;
  logic                  fifo_valid_s;
  logic [OCC_W-1:0]      occupancy_s;
  logic [OCC_W-1:0]      limit_s;
  tile_beat_t            push_beat_s;
  tile_beat_t            head_beat_s;

  // Next line address; the tile memory wraps silently at the top.
  function automatic logic [ADDR_WIDTH-1:0] line_inc(input logic [ADDR_WIDTH-1:0] line);
    if (line == ADDR_WIDTH'(BRAM_DEPTH - 1)) begin
      return {ADDR_WIDTH{1'b0}};
    end else begin
      return line + ADDR_WIDTH'(1);
    end
  endfunction

  // Bursts longer than one side of the memory are clipped to its depth.
  always_comb begin
    if (i_cmd_len > MAX_LEN) begin
      len_sat_s = MAX_LEN;
    end else begin
      len_sat_s = i_cmd_len;
    end
  end

  assign accept_s     = i_cmd_valid & cmd_ready_r;
  assign pop_s        = fifo_valid_s & i_ready;
  // A slot freed by this cycle's pop may be reused by this cycle's issue.
  assign occupancy_s  = OCC_W'(fifo_count_s) + OCC_W'(inflight_r);
  assign limit_s      = OCC_W'(FIFO_DEPTH) + OCC_W'(pop_s);
  assign credit_ok_s  = (occupancy_s < limit_s);
  assign issue_s      = (state_r == ST_ISSUE) & credit_ok_s;
  assign last_issue_s = (issue_cnt_r == (len_r - LEN_WIDTH'(1)));
  // Drained once nothing is in flight and the FIFO empties this cycle.
  assign drained_s    = ~inflight_r &
                        ((fifo_count_s == CNT_W'(0)) |
                         ((fifo_count_s == CNT_W'(1)) & pop_s));

  // Sequencer next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (len_sat_s == LEN_WIDTH'(0)) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_ISSUE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (issue_s & last_issue_s) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (drained_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State plus status flags registered from the next state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cmd_ready_r <= (state_next_s == ST_IDLE);
      busy_r      <= (state_next_s != ST_IDLE);
      done_r      <= (state_next_s == ST_DONE);
    end
  end

  // Burst bookkeeping: latch the command, then walk both sides per issue.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      len_r        <= {LEN_WIDTH{1'b0}};
      issue_cnt_r  <= {LEN_WIDTH{1'b0}};
      left_addr_r  <= {ADDR_WIDTH{1'b0}};
      right_addr_r <= {ADDR_WIDTH{1'b0}};
    end else if (accept_s) begin
      len_r        <= len_sat_s;
      issue_cnt_r  <= {LEN_WIDTH{1'b0}};
      left_addr_r  <= i_cmd_left_base;
      right_addr_r <= i_cmd_right_base;
    end else if (issue_s) begin
      issue_cnt_r  <= issue_cnt_r + LEN_WIDTH'(1);
      left_addr_r  <= line_inc(left_addr_r);
      right_addr_r <= line_inc(right_addr_r);
    end
  end

  // Track the read in flight so its data is captured next cycle; reset
  // clears it, which discards any data still returning from the BRAM.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      inflight_r      <= issue_s;
      inflight_last_r <= issue_s & last_issue_s;
    end
  end

  // Capture path from the BRAM registered outputs.
  always_comb begin
    push_beat_s           = '0;
    push_beat_s.man_left  = i_man_left_rd_data;
    push_beat_s.man_right = i_man_right_rd_data;
    push_beat_s.exp_left  = i_exp_left_rd_data;
    push_beat_s.exp_right = i_exp_right_rd_data;
    push_beat_s.last      = inflight_last_r;
  end

  tile_rd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_push      (inflight_r),
    .i_push_data (push_beat_s),
    .i_pop       (pop_s),
    .o_head      (head_beat_s),
    .o_valid     (fifo_valid_s),
    .o_count     (fifo_count_s)
  );

  assign o_cmd_ready         = cmd_ready_r;
  assign o_busy              = busy_r;
  assign o_done              = done_r;
  assign o_man_left_rd_addr  = left_addr_r;
  assign o_exp_left_rd_addr  = left_addr_r;
  assign o_man_right_rd_addr = right_addr_r;
  assign o_exp_right_rd_addr = right_addr_r;
  assign o_man_left_rd_en    = issue_s;
  assign o_man_right_rd_en   = issue_s;
  assign o_exp_left_rd_en    = issue_s;
  assign o_exp_right_rd_en   = issue_s;
  assign o_valid             = fifo_valid_s;
  assign o_man_left          = head_beat_s.man_left;
  assign o_man_right         = head_beat_s.man_right;
  assign o_exp_left          = head_beat_s.exp_left;
  assign o_exp_right         = head_beat_s.exp_right;
  assign o_last              = head_beat_s.last;

endmodule

// File: tb/tb_tile_bram_reader.sv
// Directed bench for tile_bram_reader: a behavioural tile BRAM whose line k
// holds k replicated (exp = k[7:0]), a negedge monitor that logs commands,
// reads, beats and done pulses, and hand-computed expected results.
module tb_tile_bram_reader;
  import tile_pkg::*;

  logic                  i_clk = 1'b0;
  logic                  i_reset_n;
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic [ADDR_WIDTH-1:0] i_cmd_left_base;
  logic [ADDR_WIDTH-1:0] i_cmd_right_base;
  logic [LEN_WIDTH-1:0]  i_cmd_len;
  logic [ADDR_WIDTH-1:0] o_man_left_rd_addr, o_exp_left_rd_addr;
  logic [ADDR_WIDTH-1:0] o_man_right_rd_addr, o_exp_right_rd_addr;
  logic                  o_man_left_rd_en, o_man_right_rd_en;
  logic                  o_exp_left_rd_en, o_exp_right_rd_en;
  logic [MAN_WIDTH-1:0]  i_man_left_rd_data = '0, i_man_right_rd_data = '0;
  logic [EXP_WIDTH-1:0]  i_exp_left_rd_data = '0, i_exp_right_rd_data = '0;
  logic                  o_valid;
  logic                  i_ready = 1'b1;
  logic [MAN_WIDTH-1:0]  o_man_left, o_man_right;
  logic [EXP_WIDTH-1:0]  o_exp_left, o_exp_right;
  logic                  o_last, o_busy, o_done;

  tile_bram_reader dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_left_base(i_cmd_left_base), .i_cmd_right_base(i_cmd_right_base),
    .i_cmd_len(i_cmd_len),
    .o_man_left_rd_addr(o_man_left_rd_addr), .o_exp_left_rd_addr(o_exp_left_rd_addr),
    .o_man_right_rd_addr(o_man_right_rd_addr), .o_exp_right_rd_addr(o_exp_right_rd_addr),
    .o_man_left_rd_en(o_man_left_rd_en), .o_man_right_rd_en(o_man_right_rd_en),
    .o_exp_left_rd_en(o_exp_left_rd_en), .o_exp_right_rd_en(o_exp_right_rd_en),
    .i_man_left_rd_data(i_man_left_rd_data), .i_man_right_rd_data(i_man_right_rd_data),
    .i_exp_left_rd_data(i_exp_left_rd_data), .i_exp_right_rd_data(i_exp_right_rd_data),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_man_left(o_man_left), .o_man_right(o_man_right),
    .o_exp_left(o_exp_left), .o_exp_right(o_exp_right),
    .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total_cnt++;
    if (obs == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [MAN_WIDTH-1:0] line_man(input int k);
    logic [MAN_WIDTH-1:0] r;
    for (int j = 0; j < MAN_WIDTH / 32; j++) r[j*32 +: 32] = k[31:0];
    return r;
  endfunction

  // Behavioural tile BRAM with registered read ports.
  always @(posedge i_clk) begin
    if (o_man_left_rd_en)  i_man_left_rd_data  <= line_man(int'(o_man_left_rd_addr));
    if (o_man_right_rd_en) i_man_right_rd_data <= line_man(int'(o_man_right_rd_addr));
    if (o_exp_left_rd_en)  i_exp_left_rd_data  <= o_exp_left_rd_addr[7:0];
    if (o_exp_right_rd_en) i_exp_right_rd_data <= o_exp_right_rd_addr[7:0];
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct { int l; int r; int el; int er; int last; int cyc; } beat_t;
  beat_t beats[$];
  int acc_q[$], done_q[$], rd_left_q[$];
  int rd_cnt, valid_cnt, integ_err, issued, popped, max_out, first_rd;

  task automatic clear_rec();
    beats.delete(); acc_q.delete(); done_q.delete(); rd_left_q.delete();
    rd_cnt = 0; valid_cnt = 0; integ_err = 0; issued = 0; popped = 0;
    max_out = 0; first_rd = -1;
  endtask

  // Monitor: everything sampled mid-cycle on the falling edge.
  initial forever begin
    beat_t b;
    @(negedge i_clk);
    if (i_reset_n) begin
      if (i_cmd_valid && o_cmd_ready) acc_q.push_back(cyc);
      if (o_done) done_q.push_back(cyc);
      if (o_valid) valid_cnt++;
      if ((o_man_left_rd_en != o_man_right_rd_en) || (o_man_left_rd_en != o_exp_left_rd_en) ||
          (o_man_left_rd_en != o_exp_right_rd_en) || (o_man_left_rd_addr != o_exp_left_rd_addr) ||
          (o_man_right_rd_addr != o_exp_right_rd_addr)) integ_err++;
      if (o_man_left_rd_en) begin
        rd_cnt++; issued++;
        rd_left_q.push_back(int'(o_man_left_rd_addr));
        if (first_rd < 0) first_rd = cyc;
      end
      if (o_valid && i_ready) begin
        popped++;
        b.l = int'(o_man_left[31:0]); b.r = int'(o_man_right[31:0]);
        b.el = int'(o_exp_left); b.er = int'(o_exp_right);
        b.last = int'(o_last); b.cyc = cyc;
        beats.push_back(b);
        if ((o_man_left != line_man(b.l)) || (o_man_right != line_man(b.r)) ||
            (o_exp_left != o_man_left[7:0]) || (o_exp_right != o_man_right[7:0])) integ_err++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
    end
  end

  bit toggle_mode = 1'b0;
  bit ready_force = 1'b1;
  // Consumer ready driver.
  initial forever begin
    @(posedge i_clk); #1;
    if (toggle_mode) i_ready = ~i_ready;
    else i_ready = ready_force;
  end

  task automatic issue_cmd(input int lb, input int rb, input int len);
    bit got = 1'b0;
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b1;
    i_cmd_left_base = ADDR_WIDTH'(lb);
    i_cmd_right_base = ADDR_WIDTH'(rb);
    i_cmd_len = LEN_WIDTH'(len);
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge i_clk);
      if (o_cmd_ready) got = 1'b1;
    end
    if (!got) chk("cmd_accept_timeout", 0, 1);
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_dones(input int n, input int budget);
    for (int k = 0; k < budget && done_q.size() < n; k++) @(negedge i_clk);
    if (done_q.size() < n) chk("done_timeout", done_q.size(), n);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a;
    int wrap_exp[4] = '{510, 511, 0, 1};
    i_reset_n = 1'b0; i_cmd_valid = 1'b0;
    i_cmd_left_base = '0; i_cmd_right_base = '0; i_cmd_len = '0;
    clear_rec();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_cmd_ready", int'(o_cmd_ready), 1);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_last", int'(o_last), 0);
    chk("rst_rd_en", int'({o_man_left_rd_en, o_man_right_rd_en, o_exp_left_rd_en, o_exp_right_rd_en}), 0);
    chk("rst_addr", int'(o_man_left_rd_addr) + int'(o_man_right_rd_addr), 0);
    chk("rst_data", int'(o_man_left[31:0]), 0);
    @(posedge i_clk); #1 i_reset_n = 1'b1;
    repeat (2) @(posedge i_clk);

    // Basic burst, ready held high.
    clear_rec();
    issue_cmd(0, 256, 4);
    wait_dones(1, 40);
    repeat (3) @(posedge i_clk);
    a = (acc_q.size() > 0) ? acc_q[0] : -1000;
    chk("t1_beats", beats.size(), 4);
    chk("t1_first_rd", first_rd, a + 1);
    chk("t1_rd_cnt", rd_cnt, 4);
    for (int i = 0; i < beats.size() && i < 4; i++) begin
      chk($sformatf("t1_left%0d", i), beats[i].l, i);
      chk($sformatf("t1_right%0d", i), beats[i].r, 256 + i);
      chk($sformatf("t1_expl%0d", i), beats[i].el, i);
      chk($sformatf("t1_expr%0d", i), beats[i].er, (256 + i) % 256);
      chk($sformatf("t1_last%0d", i), beats[i].last, int'(i == 3));
      chk($sformatf("t1_cyc%0d", i), beats[i].cyc, a + 3 + i);
    end
    chk("t1_done_cyc", (done_q.size() > 0) ? done_q[0] : -1, a + 7);
    chk("t1_integrity", integ_err, 0);

    // Address wrap at the top of the memory.
    clear_rec();
    issue_cmd(510, 100, 4);
    wait_dones(1, 40);
    repeat (3) @(posedge i_clk);
    chk("t2_rd_cnt", rd_left_q.size(), 4);
    for (int i = 0; i < rd_left_q.size() && i < 4; i++)
      chk($sformatf("t2_rd_addr%0d", i), rd_left_q[i], wrap_exp[i]);
    chk("t2_beats", beats.size(), 4);
    for (int i = 0; i < beats.size() && i < 4; i++) begin
      chk($sformatf("t2_left%0d", i), beats[i].l, wrap_exp[i]);
      chk($sformatf("t2_right%0d", i), beats[i].r, 100 + i);
    end
    chk("t2_integrity", integ_err, 0);

    // Backpressure: ready toggles every cycle.
    clear_rec();
    toggle_mode = 1'b1;
    issue_cmd(40, 300, 16);
    wait_dones(1, 200);
    toggle_mode = 1'b0; ready_force = 1'b1;
    repeat (3) @(posedge i_clk);
    chk("t3_beats", beats.size(), 16);
    for (int i = 0; i < beats.size() && i < 16; i++) begin
      chk($sformatf("t3_left%0d", i), beats[i].l, 40 + i);
      chk($sformatf("t3_right%0d", i), beats[i].r, 300 + i);
      chk($sformatf("t3_last%0d", i), beats[i].last, int'(i == 15));
    end
    chk("t3_rd_cnt", rd_cnt, 16);
    chk("t3_max_outstanding", max_out, 4);
    chk("t3_integrity", integ_err, 0);

    // Zero-length burst.
    clear_rec();
    issue_cmd(5, 6, 0);
    wait_dones(1, 20);
    repeat (4) @(posedge i_clk);
    a = (acc_q.size() > 0) ? acc_q[0] : -1000;
    chk("t4_done_cyc", (done_q.size() > 0) ? done_q[0] : -1, a + 1);
    chk("t4_rd_cnt", rd_cnt, 0);
    chk("t4_valid_cnt", valid_cnt, 0);

    // Asynchronous reset in the middle of a burst.
    clear_rec();
    issue_cmd(20, 30, 8);
    repeat (2) @(posedge i_clk);
    #2 i_reset_n = 1'b0;
    @(negedge i_clk);
    chk("t5_rst_cmd_ready", int'(o_cmd_ready), 1);
    chk("t5_rst_valid", int'(o_valid), 0);
    chk("t5_rst_busy", int'(o_busy), 0);
    chk("t5_rst_rd_en", int'(o_man_left_rd_en), 0);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1 i_reset_n = 1'b1;
    @(negedge i_clk);
    chk("t5_post_cmd_ready", int'(o_cmd_ready), 1);
    clear_rec();
    issue_cmd(60, 70, 2);
    wait_dones(1, 40);
    repeat (4) @(posedge i_clk);
    chk("t5_beats", beats.size(), 2);
    for (int i = 0; i < beats.size() && i < 2; i++) begin
      chk($sformatf("t5_left%0d", i), beats[i].l, 60 + i);
      chk($sformatf("t5_right%0d", i), beats[i].r, 70 + i);
      chk($sformatf("t5_last%0d", i), beats[i].last, int'(i == 1));
    end

    // Back-to-back single-beat bursts.
    clear_rec();
    issue_cmd(7, 8, 1);
    issue_cmd(9, 10, 1);
    wait_dones(2, 60);
    repeat (2) @(posedge i_clk);
    chk("t6_accepts", acc_q.size(), 2);
    chk("t6_beats", beats.size(), 2);
    if (acc_q.size() >= 2 && done_q.size() >= 2 && beats.size() >= 2) begin
      chk("t6_accept_after_done", acc_q[1], done_q[0] + 1);
      chk("t6_done2_cyc", done_q[1], acc_q[1] + 4);
      chk("t6_beat2_cyc", beats[1].cyc, acc_q[1] + 3);
      chk("t6_left0", beats[0].l, 7);
      chk("t6_left1", beats[1].l, 9);
      chk("t6_lasts", beats[0].last + beats[1].last, 2);
    end

    // Oversized length saturates to the memory depth.
    clear_rec();
    issue_cmd(3, 4, 700);
    wait_dones(1, 800);
    repeat (3) @(posedge i_clk);
    chk("t7_rd_cnt", rd_cnt, BRAM_DEPTH);
    chk("t7_beats", beats.size(), BRAM_DEPTH);
    if (beats.size() == BRAM_DEPTH) begin
      chk("t7_last_left", beats[BRAM_DEPTH-1].l, 2);
      chk("t7_last_flag", beats[BRAM_DEPTH-1].last, 1);
      chk("t7_early_last", beats[BRAM_DEPTH-2].last, 0);
    end
    chk("t7_integrity", integ_err, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
